// File: rtl/tmu_sched_if.sv
// tmu_sched_if: requester and shared-engine signals of the tmu_sched arbiter
interface tmu_sched_if #(parameter int DW = 12, parameter int RW = 17);
  logic          req_pid, req_cordic;
  logic [DW-1:0] data_pid_in, data_cordic_in;
  logic          gnt_pid, gnt_cordic;
  logic          eng_start, eng_sel;
  logic [DW-1:0] eng_din;
  logic          eng_done;
  logic [RW-1:0] eng_dout;
  logic [RW-1:0] res_pid;
  logic          res_pid_vld;
  logic [DW-1:0] res_cordic;
  logic          res_cordic_vld;
  logic          busy, timeout_err;
  modport slave (
    input  req_pid, req_cordic, data_pid_in, data_cordic_in, eng_done, eng_dout,
    output gnt_pid, gnt_cordic, eng_start, eng_sel, eng_din,
           res_pid, res_pid_vld, res_cordic, res_cordic_vld, busy, timeout_err
  );
  modport master (
    output req_pid, req_cordic, data_pid_in, data_cordic_in, eng_done, eng_dout,
    input  gnt_pid, gnt_cordic, eng_start, eng_sel, eng_din,
           res_pid, res_pid_vld, res_cordic, res_cordic_vld, busy, timeout_err
  );
endinterface

// File: rtl/tmu_sched.sv
// tmu_sched: round-robin PID/CORDIC scheduler for a shared engine; WAIT abort via TMU_SCHED_TIMEOUT_EN
module tmu_sched #(
  parameter int DW      = 12,
  parameter int RW      = 17,
  parameter int TIMEOUT = 64
) (
  input logic        clk,
  input logic        rst,
  tmu_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic          fav_q, fav_d;
  logic [DW-1:0] din_q, din_d;
  logic [RW-1:0] res_pid_q, res_pid_d;
  logic [DW-1:0] res_cordic_q, res_cordic_d;
  logic          win_c;
`ifdef TMU_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    fav_d        = fav_q;
    din_d        = din_q;
    res_pid_d    = res_pid_q;
    res_cordic_d = res_cordic_q;
    win_c        = bus.req_cordic & (~bus.req_pid | fav_q);
    if (state_q == IDLE && (bus.req_pid || bus.req_cordic)) begin
      state_d = START;
      sel_d   = win_c;
      din_d   = win_c ? bus.data_cordic_in : bus.data_pid_in;
    end
    if (state_q == START) state_d = WAIT;
    if (state_q == DONE) state_d = IDLE;
    if (state_q == WAIT && bus.eng_done) begin
      state_d      = DONE;
      fav_d        = ~sel_q;
      res_pid_d    = sel_q ? res_pid_q : bus.eng_dout;
      res_cordic_d = sel_q ? bus.eng_dout[DW-1:0] : res_cordic_q;
    end
`ifdef TMU_SCHED_TIMEOUT_EN
    err_d = err_q;
    cnt_d = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
    if (state_q == WAIT && !bus.eng_done && cnt_q == CW'(TIMEOUT - 1)) begin
      state_d = IDLE;
      fav_d   = ~sel_q;
      err_d   = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      fav_q        <= 1'b0;
      din_q        <= '0;
      res_pid_q    <= '0;
      res_cordic_q <= '0;
`ifdef TMU_SCHED_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      fav_q        <= fav_d;
      din_q        <= din_d;
      res_pid_q    <= res_pid_d;
      res_cordic_q <= res_cordic_d;
`ifdef TMU_SCHED_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end
  assign bus.gnt_pid        = (state_q == START) & ~sel_q;
  assign bus.gnt_cordic     = (state_q == START) & sel_q;
  assign bus.eng_start      = (state_q == START);
  assign bus.eng_sel        = sel_q;
  assign bus.eng_din        = din_q;
  assign bus.res_pid        = res_pid_q;
  assign bus.res_cordic     = res_cordic_q;
  assign bus.res_pid_vld    = (state_q == DONE) & ~sel_q;
  assign bus.res_cordic_vld = (state_q == DONE) & sel_q;
  assign bus.busy           = (state_q != IDLE);
`ifdef TMU_SCHED_TIMEOUT_EN
  assign bus.timeout_err    = err_q;
`else
  assign bus.timeout_err    = 1'b0;
`endif
endmodule

// File: tb/tb_tmu_sched.sv
// tb_tmu_sched: directed vector table plus reset, spurious-done, contention and timeout sequences
module tb_tmu_sched;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;
  tmu_sched_if #(.DW(12), .RW(17)) bus ();
  tmu_sched #(.DW(12), .RW(17), .TIMEOUT(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic        rp, rc;
    logic [11:0] dp, dc;
    int          lat;
    logic [16:0] dout;
    logic        sel;
    logic [11:0] din;
    logic [16:0] rpid;
    logic [11:0] rcord;
  } vec_t;
  vec_t v[7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.eng_start && n < 20);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.req_pid = 0; bus.req_cordic = 0; bus.eng_done = 0;
    bus.data_pid_in = '0; bus.data_cordic_in = '0; bus.eng_dout = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_gnt"}, {bus.gnt_pid, bus.gnt_cordic, bus.eng_start}, 0);
    chk({nm, "_sel_din"}, {bus.eng_sel, bus.eng_din}, 0);
    chk({nm, "_res"}, {bus.res_pid, bus.res_cordic}, 0);
    chk({nm, "_vld_err"}, {bus.res_pid_vld, bus.res_cordic_vld, bus.timeout_err}, 0);
  endtask
  task automatic run(input vec_t t);
    int n;
    bus.req_pid = t.rp; bus.req_cordic = t.rc;
    bus.data_pid_in = t.dp; bus.data_cordic_in = t.dc;
    wait_start(n);
    chk("grant_latency", n, 1);
    chk("gnt_pid", bus.gnt_pid, !t.sel);
    chk("gnt_cordic", bus.gnt_cordic, t.sel);
    chk("eng_sel", bus.eng_sel, t.sel);
    chk("eng_din", bus.eng_din, t.din);
    if (t.sel) bus.req_cordic = 0; else bus.req_pid = 0;
    bus.data_pid_in = 12'h5A5; bus.data_cordic_in = 12'hA5A;
    repeat (t.lat - 1) @(negedge clk);
    chk("wait_busy", bus.busy, 1);
    chk("wait_start_low", bus.eng_start, 0);
    chk("wait_stable", {bus.eng_sel, bus.eng_din}, {t.sel, t.din});
    chk("wait_no_vld", {bus.res_pid_vld, bus.res_cordic_vld}, 0);
    bus.eng_done = 1; bus.eng_dout = t.dout;
    @(negedge clk);
    bus.eng_done = 0; bus.eng_dout = 17'h0DEAD;
    chk("res_pid_vld", bus.res_pid_vld, !t.sel);
    chk("res_cordic_vld", bus.res_cordic_vld, t.sel);
    chk("res_pid", bus.res_pid, t.rpid);
    chk("res_cordic", bus.res_cordic, t.rcord);
    @(negedge clk);
    chk("back_idle", bus.busy, 0);
    chk("vld_one_cycle", {bus.res_pid_vld, bus.res_cordic_vld}, 0);
  endtask
  initial begin
    int n;
    logic saw_vld;
    v[0] = '{1, 0, 12'h123, 12'h000, 5, 17'h00ABC, 0, 12'h123, 17'h00ABC, 12'h000};
    v[1] = '{1, 1, 12'h111, 12'h222, 3, 17'h0F00F, 1, 12'h222, 17'h00ABC, 12'h00F};
    v[2] = '{1, 1, 12'h333, 12'h444, 2, 17'h12345, 0, 12'h333, 17'h12345, 12'h00F};
    v[3] = '{1, 1, 12'h555, 12'h666, 4, 17'h1FFFF, 1, 12'h666, 17'h12345, 12'hFFF};
    v[4] = '{0, 1, 12'h000, 12'hABC, 2, 17'h00001, 1, 12'hABC, 17'h12345, 12'h001};
    v[5] = '{1, 0, 12'hFFF, 12'h000, 3, 17'h10000, 0, 12'hFFF, 17'h10000, 12'h001};
    v[6] = '{0, 1, 12'h000, 12'h800, 6, 17'h0A5A5, 1, 12'h800, 17'h10000, 12'h5A5};
    do_reset();
    chk_all_zero("reset");
    for (int i = 0; i < 7; i++) run(v[i]);
    bus.req_pid = 0; bus.req_cordic = 0;
    bus.eng_done = 1; bus.eng_dout = 17'h1FFFF;
    @(negedge clk);
    bus.eng_done = 0;
    for (int i = 0; i < 2; i++) begin
      chk("spur_vld", {bus.res_pid_vld, bus.res_cordic_vld, bus.busy}, 0);
      chk("spur_res", {bus.res_pid, bus.res_cordic}, {17'h10000, 12'h5A5});
      @(negedge clk);
    end
    bus.req_cordic = 1; bus.data_cordic_in = 12'h7E7;
    wait_start(n);
    chk("mid_grant", bus.gnt_cordic, 1);
    bus.req_cordic = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk_all_zero("mid_rst");
    rst = 0;
    bus.eng_done = 1; bus.eng_dout = 17'h1ABCD;
    @(negedge clk);
    bus.eng_done = 0;
    chk_all_zero("post_rst_done");
    do_reset();
    bus.req_pid = 1; bus.req_cordic = 1;
    bus.data_pid_in = 12'hAAA; bus.data_cordic_in = 12'hBBB;
    for (int i = 0; i < 4; i++) begin
      wait_start(n);
      chk("rr_latency", n, (i == 0) ? 1 : 2);
      chk("rr_gnt", {bus.gnt_pid, bus.gnt_cordic}, (i % 2) ? 2'b01 : 2'b10);
      chk("rr_sel", bus.eng_sel, i % 2);
      chk("rr_din", bus.eng_din, (i % 2) ? 12'hBBB : 12'hAAA);
      @(negedge clk);
      bus.eng_done = 1; bus.eng_dout = 17'h00100 + 17'(i);
      @(negedge clk);
      bus.eng_done = 0;
      chk("rr_vld", {bus.res_pid_vld, bus.res_cordic_vld}, (i % 2) ? 2'b01 : 2'b10);
    end
    bus.req_pid = 0; bus.req_cordic = 0;
    @(negedge clk);
    chk("rr_res", {bus.res_pid, bus.res_cordic}, {17'h00102, 12'h103});
    bus.req_cordic = 1; bus.data_cordic_in = 12'h321;
    wait_start(n);
    chk("to_grant", bus.gnt_cordic, 1);
    bus.req_cordic = 0;
`ifdef TMU_SCHED_TIMEOUT_EN
    n = 0;
    saw_vld = 0;
    do begin
      @(negedge clk);
      n++;
      saw_vld |= bus.res_cordic_vld;
    end while (bus.busy && n < 200);
    chk("to_cycles", n, 65);
    chk("to_err", bus.timeout_err, 1);
    chk("to_no_vld", saw_vld, 0);
    bus.req_pid = 1; bus.req_cordic = 1;
    wait_start(n);
    chk("to_next_pid", {bus.gnt_pid, bus.gnt_cordic}, 2'b10);
    chk("to_err_sticky", bus.timeout_err, 1);
    bus.req_pid = 0; bus.req_cordic = 0;
    do_reset();
    chk("to_err_clr", bus.timeout_err, 0);
`else
    saw_vld = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      saw_vld |= bus.res_cordic_vld | bus.timeout_err | ~bus.busy;
    end
    chk("no_to_wait_holds", saw_vld, 0);
    bus.eng_done = 1; bus.eng_dout = 17'h00777;
    @(negedge clk);
    bus.eng_done = 0;
    chk("no_to_late_done", {bus.res_cordic_vld, bus.res_cordic}, {1'b1, 12'h777});
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
